// File: rtl/down_timer_pkg.sv
// Shared types and default sizes for the down-counting timer.
package down_timer_pkg;

  // Timer control states; the encoding is visible to anything that probes state.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } timer_state_t;

  localparam int DEFAULT_WIDTH      = 4;
  localparam int DEFAULT_PRESCALE_W = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Cycle divider: produces one tick every prescale+1 enabled cycles.
// The tick is combinational so the timer can act on it in the same cycle.
module tick_prescaler
  import down_timer_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] presc;

  // Comparing with >= lets a lowered divisor fire on the very next enabled cycle.
  assign tick = en && (presc >= prescale);

  // Divider register: cleared on a fresh launch, advances or wraps only while counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      if (tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, pause/resume and auto-reload.
// Holds the control FSM, the count/reload registers and the registered outputs.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expire
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_t     state;
  logic [WIDTH-1:0] reload;
  logic             launch;
  logic             run_en;
  logic             presc_clr;
  logic             tick;

  // A launch is a start from IDLE or DONE; resuming from PAUSED keeps the divider phase.
  // The divider only advances on cycles where the timer really counts, so a
  // pause or load issued in RUN freezes or clears it instead.
  assign launch    = start && ((state == IDLE) || (state == DONE));
  assign run_en    = (state == RUN) && !pause && !load;
  assign presc_clr = load || launch;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (run_en),
    .clr      (presc_clr),
    .prescale (prescale),
    .tick     (tick)
  );

  // Control FSM with load > pause > start priority; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      busy   <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (load) begin
        reload <= load_val;
        count  <= load_val;
        state  <= IDLE;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          DONE: begin
            if (start) begin
              count <= reload;
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          PAUSED: begin
            if (start) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (pause) begin
              state <= PAUSED;
            end else if (count == '0) begin
              // Launched with nothing to count: expire at once, even with auto-reload.
              state  <= DONE;
              busy   <= 1'b0;
              expire <= 1'b1;
            end else if (tick) begin
              if (count > ONE) begin
                count <= count - ONE;
              end else if (auto_reload && (reload != '0)) begin
                count  <= reload;
                expire <= 1'b1;
              end else begin
                count  <= '0;
                expire <= 1'b1;
                state  <= DONE;
                busy   <= 1'b0;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
